// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/port types and the round-robin pick rule for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {GRANT_IC, GRANT_DC} arb_port_t;
    function automatic arb_port_t rr_pick(input logic ic, input logic dc, input arb_port_t last);
        return (ic && dc) ? ((last == GRANT_IC) ? GRANT_DC : GRANT_IC) : (dc ? GRANT_DC : GRANT_IC);
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant; on a tie the port served last loses
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ic,
    input  logic req_dc,
    input  logic upd,
    input  logic upd_dc,
    output logic grant_dc
);
    arb_port_t last_grant;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GRANT_IC;
        else if (upd)
            last_grant <= upd_dc ? GRANT_DC : GRANT_IC;
    end
    assign grant_dc = rr_pick(req_ic, req_dc, last_grant) == GRANT_DC;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises i_cache/d_cache line requests into word beats on one memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ic_req_valid,
    output logic                         ic_req_ready,
    input  logic [ADDR_W-1:0]            ic_req_addr,
    output logic                         ic_resp_valid,
    output logic [LINE_WORDS*WORD_W-1:0] ic_resp_data,
    input  logic                         dc_req_valid,
    output logic                         dc_req_ready,
    input  logic                         dc_req_write,
    input  logic [ADDR_W-1:0]            dc_req_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] dc_req_wdata,
    output logic                         dc_resp_valid,
    output logic [LINE_WORDS*WORD_W-1:0] dc_resp_data,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic                         mem_rvalid,
    input  logic [WORD_W-1:0]            mem_rdata
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * WORD_W / 8 - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    arb_state_t state, state_nx;
    arb_port_t port;
    logic [BEAT_W-1:0] beat;
    logic write;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_WORDS-1:0][WORD_W-1:0] line_buf;
    logic grant_dc, accept, advance, capture, last;

    rr_arbiter2 u_rr (
        .clk(clk),
        .rst(rst),
        .req_ic(ic_req_valid),
        .req_dc(dc_req_valid),
        .upd(state == RESP),
        .upd_dc(port == GRANT_DC),
        .grant_dc(grant_dc)
    );

    assign last = beat == LAST_BEAT;

    always_comb begin
        state_nx = state;
        accept = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                accept = !rst && (ic_req_valid || dc_req_valid);
                state_nx = accept ? ISSUE : IDLE;
            end
            ISSUE: if (mem_ready) begin
                state_nx = !write ? WAIT : (last ? RESP : ISSUE);
                advance = write && !last;
            end
            WAIT: if (mem_rvalid) begin
                capture = 1'b1;
                state_nx = last ? RESP : ISSUE;
                advance = !last;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Fills start from a zeroed buffer so a write's data never leaks into a later fill response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            port <= GRANT_IC;
            beat <= '0;
            write <= 1'b0;
            line_addr <= '0;
            line_buf <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                port <= grant_dc ? GRANT_DC : GRANT_IC;
                write <= grant_dc && dc_req_write;
                line_addr <= (grant_dc ? dc_req_addr : ic_req_addr) & ~OFF_MASK;
                line_buf <= (grant_dc && dc_req_write) ? dc_req_wdata : '0;
                beat <= '0;
            end else if (advance)
                beat <= beat + 1'b1;
            if (capture)
                line_buf[beat] <= mem_rdata;
        end
    end

    assign ic_req_ready = accept && !grant_dc;
    assign dc_req_ready = accept && grant_dc;
    assign mem_valid = state == ISSUE;
    assign mem_write = mem_valid && write;
    assign mem_addr = mem_valid ? line_addr + ADDR_W'(beat) * WORD_BYTES : '0;
    assign mem_wdata = mem_write ? line_buf[beat] : '0;
    assign ic_resp_valid = state == RESP && port == GRANT_IC;
    assign dc_resp_valid = state == RESP && port == GRANT_DC;
    assign ic_resp_data = ic_resp_valid ? line_buf : '0;
    assign dc_resp_data = (dc_resp_valid && !write) ? line_buf : '0;
endmodule
